// File: rtl/store_pkg.sv
// Shared definitions for the store read-modify-write sequencer:
// store-size encodings, FSM states and the request legality rule.
package store_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    // A halfword must sit on an even byte address; the reserved size is never legal.
    function automatic logic is_illegal(input logic [1:0] size, input logic addr0);
        return (size == SZ_ILL) || ((size == SZ_HALF) && addr0);
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational byte-lane merge: drops the store data into the addressed
// lane(s) of the previously read memory word (little-endian lanes).
module store_lane_merge
    import store_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    input  logic [31:0] mdr,
    output logic [31:0] merged
);

    // NOTE: merged gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        merged = mdr;
        case (size)
            SZ_WORD: merged = data;
            SZ_HALF: begin
                if (addr_lo[1]) merged[31:16] = data[15:0];
                else            merged[15:0]  = data[15:0];
            end
            SZ_BYTE: begin
                case (addr_lo)
                    2'd0:    merged[7:0]   = data[7:0];
                    2'd1:    merged[15:8]  = data[7:0];
                    2'd2:    merged[23:16] = data[7:0];
                    default: merged[31:24] = data[7:0];
                endcase
            end
            default: merged = mdr;
        endcase
    end

endmodule

// File: rtl/store_rmw_sequencer.sv
// Store sequencer: word stores become one write, sub-word stores become
// read / wait MEM_LATENCY / merged write. Owns the memory port per request.
module store_rmw_sequencer
    import store_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              align_err
);

    localparam int CNT_W = 4;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       mdr_q, mdr_d;

    logic              req_ready_q, req_ready_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              done_q, done_d;
    logic              align_err_q, align_err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       merged_word;

    // NOTE: every flop, the MDR included, is cleared by the async reset so an abandoned store leaves no stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mdr_d   = mdr_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    size_d = req_size;
                    addr_d = req_addr;
                    data_d = req_data;
                    if (is_illegal(req_size, req_addr[0])) state_d = ST_ERR;
                    else if (req_size == SZ_WORD)          state_d = ST_WRITE;
                    else                                   state_d = ST_READ;
                end
            end
            ST_READ: begin
                cnt_d   = CNT_W'(MEM_LATENCY - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    mdr_d   = mem_rdata;
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Merge from the next-cycle latches so the write word is ready as WRITE is entered.
    store_lane_merge u_merge (
        .size    (size_d),
        .addr_lo (addr_d[1:0]),
        .data    (data_d),
        .mdr     (mdr_d),
        .merged  (merged_word)
    );

    // Outputs are decoded from the next state and registered, giving glitch-free strobes.
    always_comb begin
        req_ready_d = (state_d == ST_IDLE);
        mem_rd_d    = (state_d == ST_READ);
        mem_wr_d    = (state_d == ST_WRITE);
        done_d      = (state_d == ST_DONE);
        align_err_d = (state_d == ST_ERR);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if ((state_q == ST_IDLE) && (state_d == ST_READ || state_d == ST_WRITE))
            mem_addr_d = {addr_d[ADDR_W-1:2], 2'b00};
        if (state_d == ST_WRITE)
            mem_wdata_d = merged_word;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            size_q      <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            mdr_q       <= '0;
            req_ready_q <= 1'b1;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            done_q      <= 1'b0;
            align_err_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mdr_q       <= mdr_d;
            req_ready_q <= req_ready_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            done_q      <= done_d;
            align_err_q <= align_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign done      = done_q;
    assign align_err = align_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Bench for store_rmw_sequencer: two instances (latency 1 and 3) driven by
// per-instance request queues and checked cycle by cycle against a schedule model.
module tb_store_rmw_sequencer;

    localparam int N      = 2;
    localparam int MAXQ   = 256;
    localparam int BUDGET = 6000;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        int          gap;
    } req_t;

    logic        clk;
    logic        reset;
    logic        req_valid [N];
    logic        req_ready [N];
    logic [1:0]  req_size  [N];
    logic [31:0] req_addr  [N];
    logic [31:0] req_data  [N];
    logic [31:0] mem_addr  [N];
    logic        mem_rd    [N];
    logic        mem_wr    [N];
    logic [31:0] mem_rdata [N];
    logic [31:0] mem_wdata [N];
    logic        done      [N];
    logic        align_err [N];

    store_rmw_sequencer #(.MEM_LATENCY(1), .ADDR_W(32)) u_lat1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_size(req_size[0]),
        .req_addr(req_addr[0]), .req_data(req_data[0]),
        .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]),
        .mem_rdata(mem_rdata[0]), .mem_wdata(mem_wdata[0]),
        .done(done[0]), .align_err(align_err[0])
    );

    store_rmw_sequencer #(.MEM_LATENCY(3), .ADDR_W(32)) u_lat3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_size(req_size[1]),
        .req_addr(req_addr[1]), .req_data(req_data[1]),
        .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]),
        .mem_rdata(mem_rdata[1]), .mem_wdata(mem_wdata[1]),
        .done(done[1]), .align_err(align_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    logic [31:0] mem [16];

    // Per-instance request queues and driver state
    req_t        items [N][MAXQ];
    int          n_items [N];
    int          head [N];
    int          wait_cnt [N];
    bit          presenting [N];
    bit          accepted_now [N];

    // Reference model: the transaction in flight and when it was accepted
    bit          busy [N];
    int          t_acc [N];
    logic [1:0]  m_size [N];
    logic [31:0] m_addr [N];
    logic [31:0] m_data [N];

    // Memory responder and observation bookkeeping
    int          rd_cycle [N];
    logic [31:0] rd_addr [N];
    logic [31:0] last_wdata [N];
    int          done_seen [N];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic bit illegal(input logic [1:0] s, input logic [31:0] a);
        return (s == 2'b11) || (s == 2'b01 && a[0]);
    endfunction

    // Last cycle offset (from the accept edge) during which the block is busy
    function automatic int last_k(input int i);
        if (illegal(m_size[i], m_addr[i])) return 1;
        if (m_size[i] == 2'b00)            return 2;
        return 3 + lat_of(i);
    endfunction

    function automatic bit model_ready(input int i, input int c);
        return !busy[i] || (c - t_acc[i]) > last_k(i);
    endfunction

    // Byte-lane view of a store: each lane either takes store data or keeps the old word
    function automatic logic [31:0] model_merge(input logic [1:0] s, input logic [31:0] a,
                                                input logic [31:0] d, input logic [31:0] old);
        logic [31:0] r;
        r = old;
        for (int j = 0; j < 4; j++) begin
            if (s == 2'b00)                                  r[8*j +: 8] = d[8*j +: 8];
            else if (s == 2'b01 && (j / 2) == int'(a[1]))   r[8*j +: 8] = d[8*(j % 2) +: 8];
            else if (s == 2'b10 && j == int'(a[1:0]))        r[8*j +: 8] = d[7:0];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic add(input int i, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] d, input int gap);
        items[i][n_items[i]] = '{size: s, addr: a, data: d, gap: gap};
        n_items[i]++;
    endtask

    task automatic check_outputs(input int i);
        int  k, lat;
        bit  act, ill, word;
        logic [4:0] e_ctrl;
        k    = cycle - t_acc[i];
        lat  = lat_of(i);
        act  = busy[i] && k <= last_k(i);
        if (busy[i] && !act) busy[i] = 1'b0;
        ill  = act && illegal(m_size[i], m_addr[i]);
        word = act && !ill && m_size[i] == 2'b00;
        // {ready, rd, wr, done, align_err}
        e_ctrl = {!act,
                  act && !ill && !word && k == 1,
                  act && !ill && (word ? k == 1 : k == 2 + lat),
                  act && !ill && (word ? k == 2 : k == 3 + lat),
                  ill && k == 1};
        check($sformatf("d%0d_ctrl_c%0d", i, cycle),
              {27'b0, req_ready[i], mem_rd[i], mem_wr[i], done[i], align_err[i]}, {27'b0, e_ctrl});
        check($sformatf("d%0d_rd_wr_excl_c%0d", i, cycle), {31'b0, mem_rd[i] & mem_wr[i]}, 32'h0);
        if (act && !ill && (word ? k == 1 : k <= 2 + lat))
            check($sformatf("d%0d_addr_c%0d", i, cycle), mem_addr[i], {m_addr[i][31:2], 2'b00});
        if (e_ctrl[2]) begin
            check($sformatf("d%0d_wdata_c%0d", i, cycle), mem_wdata[i],
                  model_merge(m_size[i], m_addr[i], m_data[i], mem[m_addr[i][5:2]]));
            last_wdata[i] = mem_wdata[i];
        end
        if (done[i]) done_seen[i]++;
        // Memory responder: valid data exactly MEM_LATENCY cycles after the read strobe
        if (mem_rd[i]) begin
            rd_cycle[i] = cycle;
            rd_addr[i]  = mem_addr[i];
        end
        mem_rdata[i] = (cycle == rd_cycle[i] + lat) ? mem[rd_addr[i][5:2]] : ~mem[rd_addr[i][5:2]];
    endtask

    task automatic drive(input int i);
        if (accepted_now[i]) begin
            presenting[i] = 1'b0;
            head[i]++;
            wait_cnt[i] = 0;
        end
        if (!presenting[i] && head[i] < n_items[i]) begin
            if (wait_cnt[i] >= items[i][head[i]].gap) presenting[i] = 1'b1;
            else                                      wait_cnt[i]++;
        end
        req_valid[i] = presenting[i];
        if (presenting[i]) begin
            req_size[i] = items[i][head[i]].size;
            req_addr[i] = items[i][head[i]].addr;
            req_data[i] = items[i][head[i]].data;
        end else begin
            req_size[i] = 2'($urandom_range(0, 3));
            req_addr[i] = $urandom;
            req_data[i] = $urandom;
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            accepted_now[i] = 1'b0;
            if (!reset && req_valid[i] && model_ready(i, cycle)) begin
                busy[i]         = 1'b1;
                t_acc[i]        = cycle;
                m_size[i]       = req_size[i];
                m_addr[i]       = req_addr[i];
                m_data[i]       = req_data[i];
                accepted_now[i] = 1'b1;
            end
        end
        cycle++;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check_outputs(i);
            drive(i);
        end
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < N; i++)
            if (head[i] < n_items[i] || presenting[i] || busy[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_all(input string tag);
        int n;
        n = 0;
        while (!all_idle() && n < BUDGET) begin
            step();
            n++;
        end
        checks++;
        assert (all_idle()) else begin
            errors++;
            $error("FAIL %s_timeout: still busy after %0d cycles, expected idle", tag, n);
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_d%0d_ctrl", tag, i),
                  {27'b0, req_ready[i], mem_rd[i], mem_wr[i], done[i], align_err[i]}, 32'h10);
            check($sformatf("%s_d%0d_addr", tag, i), mem_addr[i], 32'h0);
            check($sformatf("%s_d%0d_wdata", tag, i), mem_wdata[i], 32'h0);
        end
    endtask

    initial begin
        int base_done [N];
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0; req_size[i] = 2'b00; req_addr[i] = '0; req_data[i] = '0;
            mem_rdata[i] = '0; n_items[i] = 0; head[i] = 0; wait_cnt[i] = 0;
            presenting[i] = 1'b0; accepted_now[i] = 1'b0; busy[i] = 1'b0; t_acc[i] = 0;
            m_size[i] = '0; m_addr[i] = '0; m_data[i] = '0; rd_cycle[i] = -100;
            rd_addr[i] = '0; last_wdata[i] = '0; done_seen[i] = 0;
        end
        for (int j = 0; j < 16; j++) mem[j] = $urandom;
        mem[4] = 32'h1122_3344;
        mem[8] = 32'h5566_7788;

        // Reset state
        step();
        step();
        check_reset_state("reset");
        reset = 1'b0;
        step();

        // Word store
        for (int i = 0; i < N; i++) add(i, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        run_all("word");
        for (int i = 0; i < N; i++) check($sformatf("t1_d%0d_wdata", i), last_wdata[i], 32'hDEAD_BEEF);

        // Byte store into lane 3 of 0x1122_3344
        for (int i = 0; i < N; i++) add(i, 2'b10, 32'h0000_0013, 32'h0000_00AB, 0);
        run_all("byte");
        for (int i = 0; i < N; i++) check($sformatf("t2_d%0d_wdata", i), last_wdata[i], 32'hAB22_3344);

        // Half store into the upper half of 0x5566_7788
        for (int i = 0; i < N; i++) add(i, 2'b01, 32'h0000_0022, 32'h0000_CAFE, 0);
        run_all("half");
        for (int i = 0; i < N; i++) check($sformatf("t3_d%0d_wdata", i), last_wdata[i], 32'hCAFE_7788);

        // Misaligned half, then the reserved size
        for (int i = 0; i < N; i++) begin
            add(i, 2'b01, 32'h0000_0021, 32'h0000_1234, 0);
            add(i, 2'b11, 32'h0000_0000, 32'h5A5A_5A5A, 0);
        end
        run_all("err");

        // Async reset in the WAIT state of a byte store
        for (int i = 0; i < N; i++) add(i, 2'b10, 32'h0000_0011, 32'h0000_0077, 0);
        step();
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("midreset");
        for (int i = 0; i < N; i++) begin
            busy[i] = 1'b0; presenting[i] = 1'b0; head[i] = n_items[i];
            wait_cnt[i] = 0; req_valid[i] = 1'b0; rd_cycle[i] = -100;
        end
        step();
        reset = 1'b0;
        repeat (6) step();
        for (int i = 0; i < N; i++) add(i, 2'b00, 32'h0000_0030, 32'h0BAD_F00D, 0);
        run_all("post_reset");
        for (int i = 0; i < N; i++) check($sformatf("t5_d%0d_wdata", i), last_wdata[i], 32'h0BAD_F00D);

        // Held req_valid with three queued requests
        for (int i = 0; i < N; i++) begin
            base_done[i] = done_seen[i];
            add(i, 2'b00, 32'h0000_0040, 32'hA5A5_0001, 0);
            add(i, 2'b10, 32'h0000_0045, 32'h0000_00C3, 0);
            add(i, 2'b01, 32'h0000_004A, 32'h0000_BEEF, 0);
        end
        run_all("b2b");
        for (int i = 0; i < N; i++)
            check($sformatf("t6_d%0d_dones", i), done_seen[i] - base_done[i], 32'd3);

        // Randomized traffic, mixed sizes (illegal included), gaps and held valid
        for (int i = 0; i < N; i++)
            for (int n = 0; n < 150; n++)
                add(i, 2'($urandom_range(0, 3)), $urandom, $urandom,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        run_all("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
